// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 lane serializer / deserializer pair.
package mux_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ALIGNED   = 1'b1
    } rx_state_t;

    // A packed word is {data[7:0], valid}.
    localparam int PAQ_W      = 9;
    localparam int IDLE_CNT_W = 4;

endpackage

// File: rtl/paq_reg9.sv
// Packed-word register with load enable; clears to zero on reset.
module paq_reg9
    import mux_pkg::*;
(
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             en,
    input  logic [PAQ_W-1:0] d,
    output logic [PAQ_W-1:0] q
);

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux1x2_8bits_rx.sv
// Receive-side 1:2 lane deserializer.
// It recovers the lane phase from the first valid word and drops sync after IDLE_LIMIT idle pairs.
//
// state     | meaning
// WAIT_SYNC | unaligned; the first valid word is taken as lane 0
// ALIGNED   | lane_phase toggles each cycle; a pair completes on phase 1
module demux1x2_8bits_rx
    import mux_pkg::*;
#(
    parameter int IDLE_LIMIT = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_000_cond,
    input  logic       valid_000_cond,
    output logic [7:0] data_00_rx,
    output logic       valid_00_rx,
    output logic [7:0] data_11_rx,
    output logic       valid_11_rx,
    output logic       pair_strobe,
    output logic       lane_phase,
    output logic       active
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_LIMIT);

    rx_state_t             state, state_nxt;
    logic                  phase_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_nxt, idle_inc;
    logic                  hold_en, pair_done, pair_idle;
    logic [PAQ_W-1:0]      in_word, hold_q, lane0_d, lane0_q, lane1_d, lane1_q;

    assign in_word   = {data_000_cond, valid_000_cond};
    assign pair_done = (state == ALIGNED) && lane_phase;
    assign pair_idle = !hold_q[0] && !valid_000_cond;
    assign idle_inc  = idle_cnt + 1'b1;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state       <= WAIT_SYNC;
            lane_phase  <= 1'b0;
            idle_cnt    <= '0;
            pair_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            lane_phase  <= phase_nxt;
            idle_cnt    <= idle_nxt;
            pair_strobe <= pair_done;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = lane_phase;
        idle_nxt  = idle_cnt;
        hold_en   = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (valid_000_cond) begin
                    hold_en   = 1'b1;
                    state_nxt = ALIGNED;
                    phase_nxt = 1'b1;
                end
            end
            ALIGNED: begin
                phase_nxt = ~lane_phase;
                if (!lane_phase) begin
                    hold_en = 1'b1;
                end else if (pair_idle) begin
                    // Reaching the limit drops sync; the counter never holds IDLE_MAX.
                    if (idle_inc == IDLE_MAX) begin
                        state_nxt = WAIT_SYNC;
                        idle_nxt  = '0;
                    end else begin
                        idle_nxt = idle_inc;
                    end
                end else begin
                    idle_nxt = '0;
                end
            end
            default: state_nxt = WAIT_SYNC;
        endcase
    end

    // Invalid words leave the lane data untouched but still clear the lane valid.
    assign lane0_d = {(hold_q[0] ? hold_q[PAQ_W-1:1] : lane0_q[PAQ_W-1:1]), hold_q[0]};
    assign lane1_d = {(valid_000_cond ? data_000_cond : lane1_q[PAQ_W-1:1]), valid_000_cond};

    paq_reg9 u_hold (
        .clk_4f (clk_4f),
        .reset  (reset),
        .en     (hold_en),
        .d      (in_word),
        .q      (hold_q)
    );

    paq_reg9 u_lane0 (
        .clk_4f (clk_4f),
        .reset  (reset),
        .en     (pair_done),
        .d      (lane0_d),
        .q      (lane0_q)
    );

    paq_reg9 u_lane1 (
        .clk_4f (clk_4f),
        .reset  (reset),
        .en     (pair_done),
        .d      (lane1_d),
        .q      (lane1_q)
    );

    assign data_00_rx  = lane0_q[PAQ_W-1:1];
    assign valid_00_rx = lane0_q[0];
    assign data_11_rx  = lane1_q[PAQ_W-1:1];
    assign valid_11_rx = lane1_q[0];
    assign active      = (state == ALIGNED);

endmodule

// File: tb/tb_demux1x2_8bits_rx.sv
// Bench for demux1x2_8bits_rx: a behavioural receiver model queues expected lane pairs,
// which are compared whenever the DUT strobes.
module tb_demux1x2_8bits_rx;

    localparam int IDLE_LIMIT = 4;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data_000_cond  = 8'h00;
    logic       valid_000_cond = 1'b0;
    logic [7:0] data_00_rx, data_11_rx;
    logic       valid_00_rx, valid_11_rx, pair_strobe, lane_phase, active;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];

    logic       m_aligned, m_phase, m_hold_v, m_strobe;
    int         m_idle;
    logic [7:0] m_hold_d, m_d0, m_d1;

    demux1x2_8bits_rx #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
        .clk_4f         (clk_4f),
        .reset          (reset),
        .data_000_cond  (data_000_cond),
        .valid_000_cond (valid_000_cond),
        .data_00_rx     (data_00_rx),
        .valid_00_rx    (valid_00_rx),
        .data_11_rx     (data_11_rx),
        .valid_11_rx    (valid_11_rx),
        .pair_strobe    (pair_strobe),
        .lane_phase     (lane_phase),
        .active         (active)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_aligned = 1'b0;
        m_phase   = 1'b0;
        m_hold_v  = 1'b0;
        m_hold_d  = 8'h00;
        m_idle    = 0;
        m_d0      = 8'h00;
        m_d1      = 8'h00;
        exp_q.delete();
    endtask

    // Drive one serial word, advance the model, then check after the edge.
    task automatic send_word(input logic [7:0] d, input logic v);
        logic [17:0] e;
        @(negedge clk_4f);
        data_000_cond  = d;
        valid_000_cond = v;
        m_strobe = 1'b0;
        if (!m_aligned) begin
            if (v) begin
                m_hold_d  = d;
                m_hold_v  = 1'b1;
                m_aligned = 1'b1;
                m_phase   = 1'b1;
            end
        end else if (!m_phase) begin
            m_hold_d = d;
            m_hold_v = v;
            m_phase  = 1'b1;
        end else begin
            if (m_hold_v) m_d0 = m_hold_d;
            if (v)        m_d1 = d;
            exp_q.push_back({m_d0, m_hold_v, m_d1, v});
            m_strobe = 1'b1;
            m_phase  = 1'b0;
            if (!m_hold_v && !v) begin
                if (m_idle + 1 == IDLE_LIMIT) begin
                    m_aligned = 1'b0;
                    m_idle    = 0;
                end else begin
                    m_idle++;
                end
            end else begin
                m_idle = 0;
            end
        end
        @(posedge clk_4f);
        #1;
        chk("strobe", 32'(pair_strobe), 32'(m_strobe));
        chk("active", 32'(active), 32'(m_aligned));
        chk("phase", 32'(lane_phase), 32'(m_phase));
        if (pair_strobe) begin
            if (exp_q.size() == 0) begin
                chk("pair_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("pair", 32'({data_00_rx, valid_00_rx, data_11_rx, valid_11_rx}), 32'(e));
            end
        end
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        reset          = 1'b1;
        data_000_cond  = 8'h00;
        valid_000_cond = 1'b0;
        #1;
        chk(tag, 32'({data_00_rx, valid_00_rx, data_11_rx, valid_11_rx,
                      pair_strobe, lane_phase, active}), 32'(0));
        model_clear();
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] d0, d1;
        logic       v0, v1;
        model_clear();

        // 1: reset state, reset during a running stream, then idle words only
        repeat (2) @(posedge clk_4f);
        #1;
        chk("por_out", 32'({data_00_rx, valid_00_rx, data_11_rx, valid_11_rx,
                            pair_strobe, lane_phase, active}), 32'(0));
        @(negedge clk_4f);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send_word(8'($urandom), 1'b1);
        do_reset("rst_running");
        for (int i = 0; i < 6; i++) send_word(8'($urandom), 1'b0);

        // 2: two valid pairs
        send_word(8'hA5, 1'b1);
        chk("t2_phase1", 32'(lane_phase), 32'(1));
        send_word(8'h3C, 1'b1);
        chk("t2_d0", 32'(data_00_rx), 32'h00A5);
        chk("t2_d1", 32'(data_11_rx), 32'h003C);
        chk("t2_v", 32'({valid_00_rx, valid_11_rx}), 32'(3));
        send_word(8'h0F, 1'b1);
        chk("t2_no_strobe", 32'(pair_strobe), 32'(0));
        send_word(8'hF0, 1'b1);
        chk("t2_d0b", 32'(data_00_rx), 32'h000F);
        chk("t2_d1b", 32'(data_11_rx), 32'h00F0);

        // 3: valid lane 0 with invalid lane 1
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b0);
        chk("t3_d0", 32'(data_00_rx), 32'h0011);
        chk("t3_v0", 32'(valid_00_rx), 32'(1));
        chk("t3_d1_hold", 32'(data_11_rx), 32'h00F0);
        chk("t3_v1", 32'(valid_11_rx), 32'(0));

        // 4: IDLE_LIMIT all-invalid pairs drop sync, then resync
        for (int i = 0; i < 2 * IDLE_LIMIT; i++) begin
            send_word(8'hEE, 1'b0);
            if (i == 2 * IDLE_LIMIT - 2) chk("t4_active_before", 32'(active), 32'(1));
        end
        chk("t4_active_drop", 32'(active), 32'(0));
        chk("t4_v_zero", 32'({valid_00_rx, valid_11_rx}), 32'(0));
        send_word(8'h55, 1'b1);
        chk("t4_resync", 32'({active, lane_phase}), 32'(3));
        send_word(8'h66, 1'b1);
        chk("t4_d0", 32'(data_00_rx), 32'h0055);

        // 5: reset with only a lane-0 word captured
        send_word(8'h77, 1'b1);
        chk("t5_phase1", 32'(lane_phase), 32'(1));
        do_reset("t5_rst");
        send_word(8'h01, 1'b0);
        send_word(8'h99, 1'b1);
        send_word(8'hAA, 1'b1);
        chk("t5_d0", 32'(data_00_rx), 32'h0099);
        chk("t5_d1", 32'(data_11_rx), 32'h00AA);

        // 6: loopback from a serializer model with random lane pairs
        for (int p = 0; p < 200; p++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            v0 = ($urandom_range(3) != 0);
            v1 = 1'($urandom);
            send_word(d0, v0);
            send_word(d1, v1);
        end

        @(negedge clk_4f);
        data_000_cond  = 8'h00;
        valid_000_cond = 1'b0;
        repeat (2) @(posedge clk_4f);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
